// File: rtl/buffer_memory_sweep.sv
// Dual-port payload buffer RAM: one write port with byte lanes, one read port
// with a 1- or 2-cycle registered read pipeline. After reset, or on request,
// a hardware sweep writes CLEAR_VALUE into every word, so the array needs no reset.
module buffer_memory_sweep #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    DEPTH       = 16384,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    WR_FIRST    = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   addr_wr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   addr_rd,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    wr_err,
  output logic                    rd_err
);

  localparam int                    NB       = DATA_WIDTH / 8;
  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;

  logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

  logic                    w_ready, w_wr_inr, w_rd_inr, w_wr_acc, w_rd_acc;
  logic [NB-1:0]           w_we_lane;
  logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_wr_data, w_mem_rd, w_merged, w_rd_word;

  logic                    r_vld_p1, r_err_p1;
  logic [DATA_WIDTH-1:0]   r_data_p1;
  logic                    r_wr_err;

  // An access is only taken in READY and never in the same cycle as a clear request.
  assign w_ready  = (r_state == S_READY) && !clear;
  assign w_wr_inr = {1'b0, addr_wr} < LP_DEPTH;
  assign w_rd_inr = {1'b0, addr_rd} < LP_DEPTH;
  assign w_wr_acc = w_ready && wr_en && w_wr_inr;
  assign w_rd_acc = w_ready && rd_en;
  assign w_wr_idx = (r_state == S_CLEAR) ? r_cnt[IDX_W-1:0] : addr_wr[IDX_W-1:0];
  assign w_rd_idx = addr_rd[IDX_W-1:0];
  assign busy     = (r_state == S_CLEAR);
  assign wr_err   = r_wr_err;

  // State and sweep-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: the sweep walks 0..DEPTH-1 and a clear request always restarts it at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (clear) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = S_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Single write port shared by the sweep (all lanes) and user writes (selected lanes).
  always_comb begin
    w_we_lane = '0;
    w_wr_data = data_in;
    if (r_state == S_CLEAR) begin
      w_we_lane = '1;
      w_wr_data = CLEAR_VALUE;
    end else if (w_wr_acc) begin
      w_we_lane = byte_en;
    end
  end

  // Array write, byte lane at a time; no reset on the storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_we_lane[i]) begin
        r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // Read word selection: out-of-range returns CLEAR_VALUE; a same-address write can be forwarded.
  always_comb begin
    w_mem_rd = r_mem[w_rd_idx];
    w_merged = w_mem_rd;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        w_merged[8*i +: 8] = data_in[8*i +: 8];
      end
    end
    if (!w_rd_inr) begin
      w_rd_word = CLEAR_VALUE;
    end else if ((WR_FIRST != 0) && w_wr_acc && (addr_wr == addr_rd)) begin
      w_rd_word = w_merged;
    end else begin
      w_rd_word = w_mem_rd;
    end
  end

  // Write error flag: refused or out-of-range write, one cycle after the attempt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && (!w_ready || !w_wr_inr);
    end
  end

  // Read stage 1: capture the word; data holds between accepted reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_rd_acc;
      r_err_p1 <= w_rd_acc && !w_rd_inr;
      if (w_rd_acc) begin
        r_data_p1 <= w_rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  r_vld_p2, r_err_p2;
    logic [DATA_WIDTH-1:0] r_data_p2;

    // Read stage 2: extra output register for timing.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_vld_p2  <= 1'b0;
        r_err_p2  <= 1'b0;
        r_data_p2 <= '0;
      end else begin
        r_vld_p2 <= r_vld_p1;
        r_err_p2 <= r_err_p1;
        if (r_vld_p1) begin
          r_data_p2 <= r_data_p1;
        end
      end
    end

    assign data_out = r_data_p2;
    assign rd_valid = r_vld_p2;
    assign rd_err   = r_err_p2;
  end else begin : g_lat1
    assign data_out = r_data_p1;
    assign rd_valid = r_vld_p1;
    assign rd_err   = r_err_p1;
  end

endmodule

// File: tb/tb_buffer_memory_sweep.sv
// Directed bench for buffer_memory_sweep. Two instances share all inputs:
// u_a is RD_LATENCY=1 / WR_FIRST=1, u_b is RD_LATENCY=2 / WR_FIRST=0, both DEPTH=16.
module tb_buffer_memory_sweep;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  addr_wr = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  byte_en = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  addr_rd = '0;

  logic        busy_a, rd_valid_a, wr_err_a, rd_err_a;
  logic [31:0] data_out_a;
  logic        busy_b, rd_valid_b, wr_err_b, rd_err_b;
  logic [31:0] data_out_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buffer_memory_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(1),
                        .WR_FIRST(1), .CLEAR_VALUE(32'h0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy_a),
    .wr_en(wr_en), .addr_wr(addr_wr), .data_in(data_in), .byte_en(byte_en),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out_a),
    .rd_valid(rd_valid_a), .wr_err(wr_err_a), .rd_err(rd_err_a));

  buffer_memory_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .RD_LATENCY(2),
                        .WR_FIRST(0), .CLEAR_VALUE(32'h0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy_b),
    .wr_en(wr_en), .addr_wr(addr_wr), .data_in(data_in), .byte_en(byte_en),
    .rd_en(rd_en), .addr_rd(addr_rd), .data_out(data_out_b),
    .rd_valid(rd_valid_b), .wr_err(wr_err_b), .rd_err(rd_err_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; addr_wr = a; data_in = d; byte_en = be;
    step();
    wr_en = 1'b0; byte_en = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy_b: got %b want 1", busy_b); end
    total++; if (data_out_a !== 32'h0) begin bad++; $display("FAIL reset_data_a: got %h want 0", data_out_a); end
    total++; if (data_out_b !== 32'h0) begin bad++; $display("FAIL reset_data_b: got %h want 0", data_out_b); end
    total++; if ({rd_valid_a, rd_err_a, wr_err_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a: got %b want 000", {rd_valid_a, rd_err_a, wr_err_a}); end
    total++; if ({rd_valid_b, rd_err_b, wr_err_b} !== 3'b000) begin bad++; $display("FAIL reset_flags_b: got %b want 000", {rd_valid_b, rd_err_b, wr_err_b}); end
  endtask

  task automatic test_sweep_after_reset();
    int n = 0;
    reset = 1'b1;
    while (busy_a === 1'b1 && n < 64) begin step(); n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL sweep_len: got %0d cycles want 16", n); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL sweep_busy_b: got %b want 0", busy_b); end
    for (int i = 0; i <= 16; i++) begin
      rd_en = (i < 16); addr_rd = 5'(i);
      step();
      if (i < 16) begin
        total++; if ({rd_valid_a, rd_err_a} !== 2'b10 || data_out_a !== 32'h0) begin
          bad++; $display("FAIL init_read_a[%0d]: got v=%b e=%b d=%h want v=1 e=0 d=0", i, rd_valid_a, rd_err_a, data_out_a); end
      end
      if (i == 0) begin
        total++; if (rd_valid_b !== 1'b0) begin bad++; $display("FAIL init_lat_b: got v=%b want 0", rd_valid_b); end
      end else begin
        total++; if (rd_valid_b !== 1'b1 || data_out_b !== 32'h0) begin
          bad++; $display("FAIL init_read_b[%0d]: got v=%b d=%h want v=1 d=0", i - 1, rd_valid_b, data_out_b); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_byte_lanes();
    do_write(5'd5, 32'h11223344, 4'hF);
    do_write(5'd5, 32'hDEADBEEF, 4'b0101);
    rd_en = 1'b1; addr_rd = 5'd5;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid_a !== 1'b1 || data_out_a !== 32'h11AD33EF) begin bad++; $display("FAIL lanes_a: got v=%b d=%h want v=1 d=11ad33ef", rd_valid_a, data_out_a); end
    total++; if (rd_valid_b !== 1'b0) begin bad++; $display("FAIL lanes_lat_b: got v=%b want 0", rd_valid_b); end
    step();
    total++; if (rd_valid_b !== 1'b1 || data_out_b !== 32'h11AD33EF) begin bad++; $display("FAIL lanes_b: got v=%b d=%h want v=1 d=11ad33ef", rd_valid_b, data_out_b); end
    total++; if (rd_valid_a !== 1'b0 || data_out_a !== 32'h11AD33EF) begin bad++; $display("FAIL lanes_hold_a: got v=%b d=%h want v=0 d=11ad33ef", rd_valid_a, data_out_a); end
  endtask

  task automatic test_rw_collision();
    wr_en = 1'b1; addr_wr = 5'd9; data_in = 32'hCAFEF00D; byte_en = 4'hF;
    rd_en = 1'b1; addr_rd = 5'd9;
    step();
    wr_en = 1'b0; rd_en = 1'b0; byte_en = '0;
    total++; if (rd_valid_a !== 1'b1 || data_out_a !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_first_a: got v=%b d=%h want v=1 d=cafef00d", rd_valid_a, data_out_a); end
    step();
    total++; if (rd_valid_b !== 1'b1 || data_out_b !== 32'h0) begin bad++; $display("FAIL rd_first_b: got v=%b d=%h want v=1 d=0", rd_valid_b, data_out_b); end
    rd_en = 1'b1; addr_rd = 5'd9;
    step();
    rd_en = 1'b0;
    total++; if (data_out_a !== 32'hCAFEF00D) begin bad++; $display("FAIL reread_a: got %h want cafef00d", data_out_a); end
    step();
    total++; if (rd_valid_b !== 1'b1 || data_out_b !== 32'hCAFEF00D) begin bad++; $display("FAIL reread_b: got v=%b d=%h want v=1 d=cafef00d", rd_valid_b, data_out_b); end
  endtask

  task automatic test_out_of_range();
    logic [4:0]  addrs [3] = '{5'd4, 5'd5, 5'd31};
    logic [31:0] expd  [3] = '{32'h0, 32'h11AD33EF, 32'h0};
    logic        expe  [3] = '{1'b0, 1'b0, 1'b1};
    do_write(5'd20, 32'hFFFFFFFF, 4'hF);
    total++; if (wr_err_a !== 1'b1 || wr_err_b !== 1'b1) begin bad++; $display("FAIL oob_wr_err: got a=%b b=%b want 1 1", wr_err_a, wr_err_b); end
    step();
    total++; if (wr_err_a !== 1'b0) begin bad++; $display("FAIL oob_wr_err_pulse: got %b want 0", wr_err_a); end
    for (int i = 0; i <= 3; i++) begin
      rd_en = (i < 3);
      if (i < 3) addr_rd = addrs[i];
      step();
      if (i < 3) begin
        total++; if (rd_valid_a !== 1'b1 || rd_err_a !== expe[i] || data_out_a !== expd[i]) begin
          bad++; $display("FAIL oob_read_a[%0d]: got v=%b e=%b d=%h want v=1 e=%b d=%h", i, rd_valid_a, rd_err_a, data_out_a, expe[i], expd[i]); end
      end
      if (i >= 1) begin
        total++; if (rd_valid_b !== 1'b1 || rd_err_b !== expe[i-1] || data_out_b !== expd[i-1]) begin
          bad++; $display("FAIL oob_read_b[%0d]: got v=%b e=%b d=%h want v=1 e=%b d=%h", i - 1, rd_valid_b, rd_err_b, data_out_b, expe[i-1], expd[i-1]); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    do_write(5'd3, 32'h12345678, 4'hF);
    rd_en = 1'b1; addr_rd = 5'd3;
    step();
    rd_en = 1'b0;
    total++; if (data_out_a !== 32'h12345678) begin bad++; $display("FAIL pre_clear_a: got %h want 12345678", data_out_a); end
    clear = 1'b1; wr_en = 1'b1; addr_wr = 5'd2; data_in = 32'h55555555; byte_en = 4'hF;
    step();
    clear = 1'b0; rd_en = 1'b1; addr_rd = 5'd3;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL clear_busy: got %b want 1", busy_a); end
    total++; if (wr_err_a !== 1'b1) begin bad++; $display("FAIL clear_cycle_wr_err: got %b want 1", wr_err_a); end
    total++; if (rd_valid_b !== 1'b1 || data_out_b !== 32'h12345678) begin bad++; $display("FAIL inflight_b: got v=%b d=%h want v=1 d=12345678", rd_valid_b, data_out_b); end
    step();
    n = 1;
    wr_en = 1'b0; rd_en = 1'b0; byte_en = '0;
    total++; if (wr_err_a !== 1'b1) begin bad++; $display("FAIL busy_wr_err: got %b want 1", wr_err_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL busy_rd_drop: got %b want 0", rd_valid_a); end
    while (busy_a === 1'b1 && n < 64) begin step(); n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL clear_len: got %0d cycles want 16", n); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; addr_rd = 5'(i);
      step();
      total++; if (rd_valid_a !== 1'b1 || data_out_a !== 32'h0) begin
        bad++; $display("FAIL post_clear_a[%0d]: got v=%b d=%h want v=1 d=0", i, rd_valid_a, data_out_a); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_flush();
    int n = 0;
    bit seen_b = 0;
    do_write(5'd3, 32'hA5A5A5A5, 4'hF);
    rd_en = 1'b1; addr_rd = 5'd3;
    step();
    rd_en = 1'b0;
    total++; if (data_out_a !== 32'hA5A5A5A5) begin bad++; $display("FAIL flush_pre_a: got %h want a5a5a5a5", data_out_a); end
    #1 reset = 1'b0;
    #1;
    total++; if (busy_a !== 1'b1 || rd_valid_a !== 1'b0 || data_out_a !== 32'h0) begin bad++; $display("FAIL async_rst_a: got b=%b v=%b d=%h want 1 0 0", busy_a, rd_valid_a, data_out_a); end
    total++; if (rd_valid_b !== 1'b0 || data_out_b !== 32'h0) begin bad++; $display("FAIL async_rst_b: got v=%b d=%h want 0 0", rd_valid_b, data_out_b); end
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rd_valid_b === 1'b1) seen_b = 1;
    end
    total++; if (seen_b !== 1'b0) begin bad++; $display("FAIL flushed_read_b: got valid %b want 0", seen_b); end
    reset = 1'b0;
    #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL midsweep_rst_busy: got %b want 1", busy_a); end
    @(posedge clk); #1 reset = 1'b1;
    while (busy_a === 1'b1 && n < 64) begin step(); n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL rst_sweep_len: got %0d cycles want 16", n); end
    rd_en = 1'b1; addr_rd = 5'd3;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid_a !== 1'b1 || data_out_a !== 32'h0) begin bad++; $display("FAIL post_rst_read: got v=%b d=%h want v=1 d=0", rd_valid_a, data_out_a); end
  endtask

  initial begin
    test_reset();
    test_sweep_after_reset();
    test_byte_lanes();
    test_rw_collision();
    test_out_of_range();
    test_clear();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_memory_sweep.md
Name: buffer_memory_sweep

Overview:
Parametrised single-clock dual-port buffer RAM for the UDP/TCP payload path, with one write port and one read port. Generalises the fixed 32-bit x 16K payload buffer. Adds byte-lane write enables, a configurable read pipeline with a valid strobe, defined read-during-write ordering and range checking. Contents are initialised by a hardware clear sweep after reset or on request, so the array maps onto block RAM with no reset on the array itself.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 14, width of both address ports.
DEPTH, 16384, number of words; 2 <= DEPTH <= 2**ADDR_WIDTH.
RD_LATENCY, 1, rd_en-to-rd_valid latency in cycles; legal values are 1 and 2.
WR_FIRST, 1, same-address read-during-write policy: 1 returns new data, 0 returns old data.
CLEAR_VALUE, 0, word written to every location by the sweep.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous request to re-run the clear sweep
busy  out  1  high while the sweep runs; all accesses are refused
wr_en  in  1  write strobe
addr_wr  in  ADDR_WIDTH  write address
data_in  in  DATA_WIDTH  write data
byte_en  in  DATA_WIDTH/8  per-byte write enable; bit i covers data_in[8i+7:8i]
rd_en  in  1  read strobe
addr_rd  in  ADDR_WIDTH  read address
data_out  out  DATA_WIDTH  read data, registered
rd_valid  out  1  one-cycle strobe marking data_out valid
wr_err  out  1  one-cycle pulse: write refused
rd_err  out  1  one-cycle pulse, coincident with rd_valid: read was out of range

Behaviour:
- States: CLEAR and READY. A sweep counter of ADDR_WIDTH bits, cnt.
- Reset asserted (reset=0), asynchronously: state=CLEAR, cnt=0, busy=1, data_out=0, rd_valid=0, rd_err=0, wr_err=0, read pipeline flushed. The array itself is not reset.
- CLEAR state:
  - Each cycle writes mem[cnt]=CLEAR_VALUE and increments cnt.
  - In the cycle cnt==DEPTH-1, the last word is written and the next state is READY. busy falls on that same edge.
  - The sweep therefore takes exactly DEPTH cycles after reset release.
  - clear asserted in CLEAR restarts the sweep: cnt=0 on the next edge.
- READY state:
  - clear=1 enters CLEAR on the next edge with cnt=0; busy=1 from that edge.
  - Writes and reads sampled in the same cycle as clear are refused as if busy.
- Accesses while busy:
  - wr_en=1 performs no write; wr_err=1 on the next cycle.
  - rd_en=1 is dropped: no rd_valid, no error.
- Write (READY, wr_en=1, addr_wr<DEPTH):
  - Only lanes with byte_en[i]=1 are updated.
  - byte_en=0 is a legal no-op with no error.
  - The result is visible to reads issued on the following cycle.
- Write with addr_wr>=DEPTH: no array change; wr_err=1 for one cycle.
- Read (READY, rd_en=1):
  - data_out and rd_valid update RD_LATENCY edges after the rd_en edge.
  - rd_valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
- Read with addr_rd>=DEPTH: data_out=CLEAR_VALUE, rd_valid=1, rd_err=1, all in the same cycle.
- data_out holds its last value whenever rd_valid=0.
- Simultaneous read and write to the same in-range address:
  - WR_FIRST=1: returns the merged word (new bytes on enabled lanes, old bytes on the rest).
  - WR_FIRST=0: returns the pre-write word.
  - Different addresses have no interaction.
- Reads already in the pipeline when clear is accepted complete normally and return pre-sweep data.
- An async reset mid-read flushes the pipeline; no rd_valid is issued for that read.
- Address widths: addresses are compared unsigned against DEPTH. cnt never exceeds DEPTH-1.

Test Plan:
- Reset release, DEPTH=16: busy stays high for exactly 16 cycles. Then read addresses 0..15: each returns 0x00000000 with rd_valid exactly 1 cycle later (RD_LATENCY=1).
- Write 0xDEADBEEF to address 5 with byte_en=4'b0101, over prior content 0x11223344. A later read of address 5 returns 0x11AD33EF. With RD_LATENCY=2, rd_valid arrives 2 cycles after rd_en.
- Same-cycle write of 0xCAFEF00D (byte_en=4'hF) and read, both at address 9, prior content 0: WR_FIRST=1 returns 0xCAFEF00D; WR_FIRST=0 returns 0x00000000.
- DEPTH=16: write to address 20 gives a wr_err pulse and address 20 mod 16 is unchanged. Read of address 31 returns 0 with rd_valid=1 and rd_err=1.
- Pulse clear during READY: busy=1 for 16 cycles; wr_en during the sweep gives wr_err. A read issued the cycle before clear returns old data. After the sweep, all locations read 0.
- Assert reset for 1 cycle mid-sweep and while a read is in flight: outputs return to reset values immediately, no rd_valid for the flushed read, and a full 16-cycle sweep follows.
